// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl_pkg
//  Purpose  : CSR indices, cause codes, FSM encoding and mstatus helpers
//             shared by the machine-mode trap controller.
//  Revision : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

    // Machine-mode CSR indices
    localparam logic [11:0] c_csr_mstatus = 12'h300;
    localparam logic [11:0] c_csr_mie     = 12'h304;
    localparam logic [11:0] c_csr_mtvec   = 12'h305;
    localparam logic [11:0] c_csr_mepc    = 12'h341;
    localparam logic [11:0] c_csr_mcause  = 12'h342;
    localparam logic [11:0] c_csr_mip     = 12'h344;

    // mcause encodings
    localparam logic [63:0] c_cause_m_timer    = 64'h8000_0000_0000_0007;
    localparam logic [63:0] c_cause_ecall_m    = 64'd11;
    localparam logic [63:0] c_cause_breakpoint = 64'd3;

    // Controller FSM encoding
    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_w_mepc   = 3'd1;
    localparam logic [2:0] c_st_w_mcause = 3'd2;
    localparam logic [2:0] c_st_w_mstat  = 3'd3;
    localparam logic [2:0] c_st_redir    = 3'd4;

    typedef struct packed {
        logic irq;
        logic ecall;
        logic ebreak;
        logic mret;
    } trap_evt_t;

    // Trap entry: stack MIE into MPIE, disable interrupts, record M-mode as previous
    function automatic logic [63:0] mstatus_on_trap(input logic [63:0] ms);
        logic [63:0] r;
        r        = ms;
        r[12:11] = 2'b11;
        r[7]     = ms[3];
        r[3]     = 1'b0;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE, set MPIE, drop MPP to U
    function automatic logic [63:0] mstatus_on_mret(input logic [63:0] ms);
        logic [63:0] r;
        r        = ms;
        r[12:11] = 2'b00;
        r[3]     = ms[7];
        r[7]     = 1'b1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl_if
//  Purpose  : Retire-stage events, CSR state, CSR write port and fetch
//             redirect handshake of the trap controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface trap_ctrl_if;
    logic        inst_valid;
    logic [63:0] inst_addr;
    logic        inst_ecall;
    logic        inst_ebreak;
    logic        inst_mret;
    logic        clint_mtip;
    logic [63:0] mstatus_q;
    logic [63:0] mie_q;
    logic [63:0] mtvec_q;
    logic [63:0] mepc_q;

    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic        flush;
    logic        busy;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        redirect_ready;

    // Core/fetch side
    modport master (
        output inst_valid, inst_addr, inst_ecall, inst_ebreak, inst_mret,
        output clint_mtip, mstatus_q, mie_q, mtvec_q, mepc_q, redirect_ready,
        input  csr_we, csr_waddr, csr_wdata, flush, busy, redirect_valid, redirect_pc
    );

    // Trap controller side
    modport slave (
        input  inst_valid, inst_addr, inst_ecall, inst_ebreak, inst_mret,
        input  clint_mtip, mstatus_q, mie_q, mtvec_q, mepc_q, redirect_ready,
        output csr_we, csr_waddr, csr_wdata, flush, busy, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/trap_ctrl_prio.sv
`default_nettype none
// ============================================================================
//  Module   : trap_prio
//  Purpose  : Fixed-priority event arbiter: irq > ecall > ebreak > mret.
//  Revision : 1.0 - initial release
// ============================================================================
module trap_prio
    import trap_ctrl_pkg::*;
(
    input  trap_evt_t   i_evt,
    output logic [3:0]  o_grant,   // {irq, ecall, ebreak, mret}
    output logic [63:0] o_cause
);

    always_comb begin
        o_grant = 4'b0000;
        o_cause = 64'd0;
        if (i_evt.irq) begin
            o_grant = 4'b1000;
            o_cause = c_cause_m_timer;
        end else if (i_evt.ecall) begin
            o_grant = 4'b0100;
            o_cause = c_cause_ecall_m;
        end else if (i_evt.ebreak) begin
            o_grant = 4'b0010;
            o_cause = c_cause_breakpoint;
        end else if (i_evt.mret) begin
            o_grant = 4'b0001;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl
//  Purpose  : Machine-mode trap/mret sequencer: writes mepc/mcause/mstatus
//             one CSR per cycle, then holds a fetch redirect until accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    trap_ctrl_if.slave    bus
);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [63:0] r_epc;
    logic [63:0] r_cause;
    logic        r_is_mret;
    logic [63:0] r_redirect_pc;

    trap_evt_t   w_evt;
    logic [3:0]  w_grant;
    logic [63:0] w_cause;
    logic        w_irq_pend;
    logic        w_accept;
    logic        w_redir_done;

    logic        w_csr_we;
    logic [11:0] w_csr_waddr;
    logic [63:0] w_csr_wdata;

    logic        w_unused;

    assign w_irq_pend = bus.mstatus_q[3] & bus.mie_q[7] & bus.clint_mtip;

    assign w_evt.irq    = bus.inst_valid & w_irq_pend;
    assign w_evt.ecall  = bus.inst_valid & bus.inst_ecall;
    assign w_evt.ebreak = bus.inst_valid & bus.inst_ebreak;
    assign w_evt.mret   = bus.inst_valid & bus.inst_mret;

    trap_prio u_prio (
        .i_evt   (w_evt),
        .o_grant (w_grant),
        .o_cause (w_cause)
    );

    // Events are only looked at in IDLE, so anything arriving while busy
    // (including a timer interrupt) is simply re-evaluated afterwards.
    assign w_accept     = (r_state == c_st_idle) && (w_grant != 4'b0000);
    assign w_redir_done = (r_state == c_st_redir) && bus.redirect_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:     if (w_accept) w_state_nxt = w_grant[0] ? c_st_w_mstat : c_st_w_mepc;
            c_st_w_mepc:   w_state_nxt = c_st_w_mcause;
            c_st_w_mcause: w_state_nxt = c_st_w_mstat;
            c_st_w_mstat:  w_state_nxt = c_st_redir;
            c_st_redir:    if (bus.redirect_ready) w_state_nxt = c_st_idle;
            default:       w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_epc         <= 64'd0;
            r_cause       <= 64'd0;
            r_is_mret     <= 1'b0;
            r_redirect_pc <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_epc     <= bus.inst_addr;
                r_cause   <= w_cause;
                r_is_mret <= w_grant[0];
            end
            // Target is captured once on REDIR entry so it stays stable under backpressure
            if (r_state == c_st_w_mstat) begin
                r_redirect_pc <= r_is_mret ? bus.mepc_q : {bus.mtvec_q[63:2], 2'b00};
            end else if (w_redir_done) begin
                r_redirect_pc <= 64'd0;
            end
        end
    end

    always_comb begin
        w_csr_we    = 1'b0;
        w_csr_waddr = 12'd0;
        w_csr_wdata = 64'd0;
        case (r_state)
            c_st_w_mepc: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = c_csr_mepc;
                w_csr_wdata = r_epc;
            end
            c_st_w_mcause: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = c_csr_mcause;
                w_csr_wdata = r_cause;
            end
            c_st_w_mstat: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = c_csr_mstatus;
                w_csr_wdata = r_is_mret ? mstatus_on_mret(bus.mstatus_q)
                                        : mstatus_on_trap(bus.mstatus_q);
            end
            default: begin
                w_csr_we    = 1'b0;
                w_csr_waddr = 12'd0;
                w_csr_wdata = 64'd0;
            end
        endcase
    end

    assign bus.csr_we         = w_csr_we;
    assign bus.csr_waddr      = w_csr_waddr;
    assign bus.csr_wdata      = w_csr_wdata;
    // Flush is combinational off the accept; gated so reset silences it immediately
    assign bus.flush          = w_accept & ~rst;
    assign bus.busy           = (r_state != c_st_idle);
    assign bus.redirect_valid = (r_state == c_st_redir);
    assign bus.redirect_pc    = r_redirect_pc;

    assign w_unused = ^{bus.mie_q[63:8], bus.mie_q[6:0], bus.mtvec_q[1:0]};

endmodule
`default_nettype wire
